// File: rtl/alu_exec.sv
// -----------------------------------------------------------------------------
// alu_exec : execution-stage ALU with a registered two-entry output buffer.
//
// The operation is evaluated combinationally from the inputs and captured on
// accept. The main entry (M) drives the outputs. A skid entry (S) holds a
// second result when the consumer stalls, so the upstream stage never loses
// an operation. Results leave strictly in arrival order.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operation presented
//   in_ready   out  operation can be accepted this cycle (registered, = ~sv)
//   alucontrol in   010 add, 110 sub, 000 and, 001 or, 111 slt, else illegal
//   srca/srcb  in   operands, WIDTH bits
//   out_valid  out  main entry holds a valid result
//   out_ready  in   consumer takes the result this cycle
//   result     out  operation result
//   zero       out  result == 0
//   overflow   out  signed overflow (add/sub only)
//   illegal    out  alucontrol was an undefined code
// -----------------------------------------------------------------------------
module alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alucontrol,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  // Entry layout: {illegal, overflow, zero, result}
  localparam int EW = WIDTH + 3;

  // Evaluate one ALU operation into a packed entry.
  function automatic logic [EW-1:0] alu_eval(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] r;
    logic             ovf;
    logic             ill;
    r   = '0;
    ovf = 1'b0;
    ill = 1'b0;
    case (op)
      3'b010: begin
        r   = a + b;
        // Like-signed operands producing a differently-signed sum.
        ovf = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      3'b110: begin
        r   = a - b;
        // Unlike-signed operands with the difference sign leaving srca's.
        ovf = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b111: r[0] = ($signed(a) < $signed(b));
      default: ill = 1'b1;
    endcase
    return {ill, ovf, (r == '0), r};
  endfunction

  logic [EW-1:0] new_s;
  logic [EW-1:0] m_q, m_d;
  logic [EW-1:0] s_q, s_d;
  logic          mv_q, mv_d;
  logic          sv_q, sv_d;
  logic          accept_s;
  logic          retire_s;

  // Combinational ALU result for the operation currently presented.
  always_comb begin
    new_s = alu_eval(alucontrol, srca, srcb);
  end

  // Handshake qualifiers; in_ready is ~sv_q so no out_ready path reaches it.
  always_comb begin
    accept_s = in_valid & ~sv_q;
    retire_s = mv_q & out_ready;
  end

  // Buffer next-state: fill M or S on accept, shift S into M on retire.
  always_comb begin
    m_d  = m_q;
    s_d  = s_q;
    mv_d = mv_q;
    sv_d = sv_q;
    if (sv_q) begin
      // Full: accept is blocked; only a retire can make progress.
      if (retire_s) begin
        m_d  = s_q;
        sv_d = 1'b0;
      end else begin
        sv_d = 1'b1;
      end
    end else if (accept_s) begin
      if (!mv_q || retire_s) begin
        m_d  = new_s;
        mv_d = 1'b1;
      end else begin
        s_d  = new_s;
        sv_d = 1'b1;
      end
    end else if (retire_s) begin
      mv_d = 1'b0;
    end else begin
      mv_d = mv_q;
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q  <= '0;
      s_q  <= '0;
      mv_q <= 1'b0;
      sv_q <= 1'b0;
    end else begin
      m_q  <= m_d;
      s_q  <= s_d;
      mv_q <= mv_d;
      sv_q <= sv_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    in_ready  = ~sv_q;
    out_valid = mv_q;
    result    = m_q[WIDTH-1:0];
    zero      = m_q[WIDTH];
    overflow  = m_q[WIDTH+1];
    illegal   = m_q[WIDTH+2];
  end

endmodule

// File: tb/tb_alu_exec.sv
module tb_alu_exec;

  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    alucontrol;
  logic [W-1:0]  srca;
  logic [W-1:0]  srcb;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          zero;
  logic          overflow;
  logic          illegal;

  int n_vec;
  int n_err;

  alu_exec #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alucontrol (alucontrol),
    .srca       (srca),
    .srcb       (srcb),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .overflow   (overflow),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model from the arithmetic rules: returns {illegal, overflow, zero, result}.
  function automatic logic [W+2:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, s;
    longint lo, hi;
    logic [W-1:0] r;
    logic ovf, ill;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lo = -(64'sd1 <<< (W - 1));
    hi = (64'sd1 <<< (W - 1)) - 64'sd1;
    r = '0; ovf = 1'b0; ill = 1'b0;
    case (op)
      3'b010: begin s = sa + sb; r = s[W-1:0]; ovf = (s > hi) || (s < lo); end
      3'b110: begin s = sa - sb; r = s[W-1:0]; ovf = (s > hi) || (s < lo); end
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b111: r = (sa < sb) ? 32'd1 : 32'd0;
      default: ill = 1'b1;
    endcase
    return {ill, ovf, (r == 32'd0), r};
  endfunction

  task automatic drive(input logic v, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic ordy);
    in_valid = v; alucontrol = op; srca = a; srcb = b; out_ready = ordy;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    #3;
    n_vec++;
    if ({out_valid, in_ready, result, zero, overflow, illegal} !== {1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset: got ov=%b ir=%b r=%h z=%b o=%b i=%b, want ov=0 ir=1 r=0 flags=0",
               out_valid, in_ready, result, zero, overflow, illegal);
    end
    @(negedge clk);
  endtask

  task automatic test_ops();
    logic [2:0]   op  [6] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b100};
    logic [W-1:0] a   [6] = '{32'h7FFF_FFFF, 32'd5, 32'h0000_F0F0, 32'h0000_F000, 32'hFFFF_FFFF, 32'd3};
    logic [W-1:0] b   [6] = '{32'd1, 32'd5, 32'h0000_0FF0, 32'h0000_000F, 32'd1, 32'd4};
    logic [W+2:0] exp [6] = '{{3'b010, 32'h8000_0000}, {3'b001, 32'd0}, {3'b000, 32'h0000_00F0},
                             {3'b000, 32'h0000_F00F}, {3'b000, 32'd1}, {3'b101, 32'd0}};
    step();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, op[i], a[i], b[i], 1'b1);
      step();
      drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b1);
      n_vec++;
      if (!out_valid || {illegal, overflow, zero, result} !== exp[i] || ref_alu(op[i], a[i], b[i]) !== exp[i]) begin
        n_err++;
        $display("FAIL op%0d: got ov=%b {i,o,z,r}=%h, want ov=1 %h", i, out_valid,
                 {illegal, overflow, zero, result}, exp[i]);
      end
    end
    step();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ops_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 3'b010, 32'd1, 32'd1, 1'b0);
    step();
    n_vec++;
    if ({out_valid, in_ready, result} !== {1'b1, 1'b1, 32'd2}) begin
      n_err++;
      $display("FAIL bp_first: ov=%b ir=%b r=%0d want 1 1 2", out_valid, in_ready, result);
    end
    drive(1'b1, 3'b110, 32'd9, 32'd2, 1'b0);
    step();
    n_vec++;
    if ({out_valid, in_ready, result} !== {1'b1, 1'b0, 32'd2}) begin
      n_err++;
      $display("FAIL bp_full: ov=%b ir=%b r=%0d want 1 0 2", out_valid, in_ready, result);
    end
    drive(1'b1, 3'b001, 32'hFF, 32'h100, 1'b0);
    step();
    step();
    n_vec++;
    if ({out_valid, in_ready, result} !== {1'b1, 1'b0, 32'd2}) begin
      n_err++;
      $display("FAIL bp_hold: ov=%b ir=%b r=%0d want 1 0 2", out_valid, in_ready, result);
    end
    drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b1);
    step();
    n_vec++;
    if ({out_valid, in_ready, result, overflow} !== {1'b1, 1'b1, 32'd7, 1'b0}) begin
      n_err++;
      $display("FAIL bp_second: ov=%b ir=%b r=%0d o=%b want 1 1 7 0", out_valid, in_ready, result, overflow);
    end
    step();
    n_vec++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL bp_drop3: ov=%b ir=%b want 0 1 (third op must be ignored)", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic [W+2:0] exp;
    for (int i = 0; i < 10; i++) begin
      op = (i % 2 == 0) ? 3'b010 : 3'b110;
      a = $urandom; b = $urandom;
      exp = ref_alu(op, a, b);
      drive(1'b1, op, a, b, 1'b1);
      step();
      n_vec++;
      if (!out_valid || !in_ready || {illegal, overflow, zero, result} !== exp) begin
        n_err++;
        $display("FAIL b2b%0d: ov=%b ir=%b got %h want %h", i, out_valid, in_ready,
                 {illegal, overflow, zero, result}, exp);
      end
    end
    drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b1);
    step();
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 3'b010, 32'd3, 32'd4, 1'b0);
    step();
    drive(1'b1, 3'b001, 32'h7FFF_FFFF, 32'd1, 1'b0);
    step();
    drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_fill: in_ready=%b want 0", in_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, in_ready, result, zero, overflow, illegal} !== {1'b0, 1'b1, 32'd0, 3'b000}) begin
      n_err++;
      $display("FAIL rst_mid: ov=%b ir=%b r=%h z=%b o=%b i=%b want 0 1 0 0 0 0",
               out_valid, in_ready, result, zero, overflow, illegal);
    end
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_random();
    logic [W+2:0] sb[$];
    logic [W-1:0] corner [5] = '{32'd0, 32'd1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [W+2:0] cur, prev;
    logic         stalled;
    logic         acc, ret;
    int           n_acc, cyc;
    n_acc = 0; cyc = 0; stalled = 1'b0; prev = '0;
    drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    while ((n_acc < 1000 || sb.size() > 0) && cyc < 20000) begin
      @(negedge clk);
      cur = {illegal, overflow, zero, result};
      n_vec++;
      if (out_valid !== (sb.size() > 0) || in_ready !== (sb.size() < 2)) begin
        n_err++;
        $display("FAIL rnd_hs cyc%0d: ov=%b ir=%b want ov=%b ir=%b", cyc, out_valid, in_ready,
                 sb.size() > 0, sb.size() < 2);
      end
      if (sb.size() > 0) begin
        n_vec++;
        if (cur !== sb[0]) begin
          n_err++;
          $display("FAIL rnd_data cyc%0d: got %h want %h", cyc, cur, sb[0]);
        end
      end
      if (stalled) begin
        n_vec++;
        if (cur !== prev) begin
          n_err++;
          $display("FAIL rnd_stable cyc%0d: got %h want %h", cyc, cur, prev);
        end
      end
      acc = in_valid && (sb.size() < 2);
      ret = (sb.size() > 0) && out_ready;
      stalled = (sb.size() > 0) && !out_ready;
      prev = cur;
      if (ret) void'(sb.pop_front());
      if (acc) begin
        sb.push_back(ref_alu(alucontrol, srca, srcb));
        n_acc++;
      end
      step();
      cyc++;
      drive((n_acc < 1000) && ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 32'($urandom),
            ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 32'($urandom),
            $urandom_range(0, 2) != 0);
    end
    n_vec++;
    if (cyc >= 20000) begin
      n_err++;
      $display("FAIL rnd_timeout: accepted %0d pending %0d want 1000 0", n_acc, sb.size());
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b1;
    test_reset();
    test_ops();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execution-stage ALU that consumes the 3-bit alucontrol code produced by the ALU decoder, plus two operands.
- Computes result and flags, then holds them in a registered 2-entry output buffer (main + skid) behind valid/ready handshakes.
- Lets the datapath stall downstream without dropping operations.
- Sits between decode/register-read and the memory/writeback stage.

Parameters:
- WIDTH, 32, operand/result width in bits (>= 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  block can accept an operation this cycle.
- alucontrol  input  3  operation code: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- srca  input  WIDTH  operand A.
- srcb  input  WIDTH  operand B.
- out_valid  output  1  result registers hold a valid operation.
- out_ready  input  1  consumer takes result this cycle.
- result  output  WIDTH  operation result.
- zero  output  1  result == 0.
- overflow  output  1  signed overflow (add/sub only).
- illegal  output  1  alucontrol was an undefined code.

Behaviour:
- Reset (async, rst_n low): main valid mv=0, skid valid sv=0, result=0, zero=0, overflow=0, illegal=0, out_valid=0. in_ready=1 immediately after reset. A reset mid-operation discards both buffered entries.
- Handshakes:
  - Accept occurs on a clk edge with in_valid & in_ready.
  - Retire occurs on a clk edge with out_valid & out_ready.
  - Inputs are sampled only on accept; out_* is stable while out_valid & ~out_ready.
- Arithmetic, all WIDTH bits, computed combinationally from inputs and registered on accept:
  - add: srca+srcb, carry discarded; overflow = operand signs equal and result sign differs.
  - sub: srca-srcb; overflow = operand signs differ and result sign differs from srca.
  - and / or: bitwise; overflow=0.
  - slt: signed compare; result = {0..0, srca<srcb}; overflow=0.
  - codes 011, 100, 101: result=0, overflow=0, illegal=1.
  - zero = (result==0) for all codes, including illegal (zero=1).
- Buffer: main register M drives outputs, out_valid=mv; skid register S.
- in_ready = ~sv. It is a registered function, with no combinational path from out_ready.
- Per-edge update:
  - accept & (~mv | retire) & ~sv: M<=new, mv=1.
  - accept & mv & ~retire: S<=new, sv=1 (in_ready falls next cycle).
  - retire & sv: M<=S, sv=0, mv stays 1. Accept is impossible when sv=1.
  - retire & ~accept & ~sv: mv=0. Data registers keep their last value.
- Latency: accept at edge N -> out_valid high after edge N (1 cycle), given M empty or retiring.
- Throughput: 1 op/cycle sustained with out_ready held high. Ordering is strictly FIFO.
- Full condition: mv=1, sv=1 -> in_ready=0. Inputs are ignored until a retire.

Test Plan:
- Reset mid-stream: fill both entries, pulse rst_n low asynchronously -> out_valid=0 and in_ready=1 before the next clk edge; all flags 0.
- Ops, out_ready=1, WIDTH=32, one cycle each:
  - add 0x7FFFFFFF+1 -> result 0x80000000, overflow=1.
  - sub 5-5 -> result 0, zero=1, overflow=0.
  - and 0xF0F0+0x0FF0 -> result 0x00F0.
  - or 0xF000|0x000F -> result 0xF00F.
  - slt 0xFFFFFFFF vs 1 -> result 1.
  - Each result must appear 1 cycle after its accept.
- Illegal code 100 with srca=3, srcb=4 -> result 0, zero=1, illegal=1, overflow=0.
- Backpressure: hold out_ready=0, send add 1+1 then sub 9-2 -> in_ready=0 after the second accept; a third op is ignored. Raise out_ready -> outputs 2 then 7 on consecutive cycles; in_ready returns to 1.
- Simultaneous accept and retire with only M full: stream 10 ops with out_ready=1 -> 10 consecutive results in order, sv never set.
- Random valid/ready toggling over 1000 ops against a scoreboard -> no loss, no duplication, FIFO order, outputs stable while stalled.
